sys_pll_rst_ctrl: RTL
=====================

Name: sys_pll_rst_ctrl

Overview:
- Power-up and relock sequencer for the system PLL.
- Drives the PLL reset, qualifies the PLL locked output and issues the system-wide reset request.
- Runs in the PLL reference clock domain (24 MHz board oscillator) so it keeps working when the PLL output clocks are absent.
- Retries failed locks up to a limit, re-sequences on loss of lock, and exposes status counters to software.

Parameters:
- RST_CYCLES, 24: cycles pll_rst is held high per PLL reset pulse (1 us at 24 MHz).
- LOCK_TIMEOUT, 24000: cycles to wait for lock after pll_rst deasserts (1 ms).
- STABLE_CYCLES, 240: cycles synchronised lock must stay high before release (10 us).
- MAX_RETRY, 7: PLL reset retries after timeout before entering FAIL.
- CNT_W, 16: width of the shared cycle counter; must hold the largest of the three cycle parameters.

Ports:
- refclk  in  1  reference clock, the only clock.
- rst  in  1  reset, synchronous to refclk, active-high.
- pll_locked  in  1  PLL locked output, asynchronous to refclk.
- reinit  in  1  one-cycle request to re-sequence the PLL from scratch.
- pll_rst  out  1  reset to the PLL, active-high.
- sys_rst  out  1  system reset request, active-high.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- state  out  3  current state encoding.
- retry_cnt  out  3  timeout retries in the current sequence.
- lock_loss_cnt  out  8  count of lock losses in RUN; saturates at 255.

Behaviour:
- Reset (rst=1 at a refclk edge):
  - state=PLL_RST, counter=0, sync flops=0.
  - pll_rst=1, sys_rst=1, ready=0, fail=0, retry_cnt=0, lock_loss_cnt=0.
  - rst mid-operation aborts any state identically.
- Lock synchroniser: pll_locked passes through two flops to produce lk_s; lk_s is the only lock input used by the FSM.
- State encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- Output decode, all taken from the state register (glitch-free, no combinational path from inputs):
  - pll_rst=1 in PLL_RST and FAIL.
  - sys_rst=0 only in RUN.
  - ready=(state==RUN), fail=(state==FAIL).
- The counter clears on every state entry.
- PLL_RST:
  - Counter increments each cycle.
  - When counter==RST_CYCLES-1, go to WAIT_LOCK, so pll_rst is high exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - If lk_s=1, go to STABLE.
  - Else, if counter==LOCK_TIMEOUT-1:
    - retry_cnt==MAX_RETRY: go to FAIL.
    - otherwise: retry_cnt+1, go to PLL_RST.
  - Else counter+1.
- STABLE:
  - If lk_s=0, go to WAIT_LOCK; retry_cnt unchanged; the timeout window restarts.
  - Else, if counter==STABLE_CYCLES-1, go to RUN and clear retry_cnt.
  - Else counter+1.
  - STABLE therefore lasts exactly STABLE_CYCLES cycles when lock holds.
- RUN:
  - If lk_s=0, go to PLL_RST and increment lock_loss_cnt (saturating at 255).
  - No retry increment.
- FAIL:
  - Terminal state; holds pll_rst=1 and sys_rst=1.
  - Left only via rst or reinit.
- reinit:
  - Has priority over every lock and timeout event in every state, including PLL_RST.
  - Next state=PLL_RST, counter=0, retry_cnt=0.
  - lock_loss_cnt unchanged, even if lk_s=0 in RUN in the same cycle.
- Release latency: the first edge sampling pll_locked=1 while in WAIT_LOCK is edge k; RUN and ready=1 take effect after edge k+2+STABLE_CYCLES.

Test Plan (all scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2):
- Normal power-up:
  - Stimulus: release rst; assert pll_locked 3 cycles into WAIT_LOCK and hold it.
  - Required: pll_rst high exactly 4 cycles; ready=1 and sys_rst=0 exactly 10 edges after pll_locked is first sampled high; retry_cnt=0.
- Lock glitch during STABLE:
  - Stimulus: drop pll_locked for 1 cycle after 5 STABLE cycles.
  - Required: state returns to WAIT_LOCK (1), then STABLE restarts a full 8 cycles; retry_cnt stays 0; pll_rst stays 0.
- Timeout to FAIL:
  - Stimulus: pll_locked held 0 throughout.
  - Required: three 4-cycle pll_rst pulses, each followed by 20 WAIT_LOCK cycles, with retry_cnt 0→1→2; then state=4, fail=1, pll_rst=1, sys_rst=1, held indefinitely.
- Lock loss in RUN:
  - Stimulus: drop pll_locked in RUN.
  - Required: 2 cycles later state=PLL_RST, sys_rst=1, ready=0, lock_loss_cnt=1, followed by a full re-sequence.
  - Also repeat the loss 256 times: lock_loss_cnt reads 255.
- reinit precedence:
  - Stimulus: pulse reinit in FAIL; separately, pulse reinit in the same cycle that lk_s falls in RUN.
  - Required: both cases go to PLL_RST with retry_cnt=0 and fail=0; lock_loss_cnt unchanged in the second case.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during STABLE with lock_loss_cnt=3.
  - Required: state=0, all counters 0, pll_rst=1, sys_rst=1, ready=0 on the next edge.

Source files
------------

// File: rtl/sys_pll_rst_ctrl.sv
// System PLL power-up / relock sequencer. Runs entirely on the reference clock so it
// keeps sequencing while the PLL outputs are absent. Pulses the PLL reset, waits for a
// qualified lock, holds the system in reset until lock has been stable, retries failed
// locks up to a limit and re-sequences on loss of lock.
module sys_pll_rst_ctrl #(
  parameter int unsigned RST_CYCLES    = 24,
  parameter int unsigned LOCK_TIMEOUT  = 24000,
  parameter int unsigned STABLE_CYCLES = 240,
  parameter int unsigned MAX_RETRY     = 7,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       refclk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       reinit_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [2:0] state_o,
  output logic [2:0] retry_cnt_o,
  output logic [7:0] lock_loss_cnt_o
);

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RstLast    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LockLast   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [2:0]       MaxRetry   = 3'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             lk_meta_q, lk_s_q;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      lk_meta_q <= 1'b0;
      lk_s_q    <= 1'b0;
    end else begin
      lk_meta_q <= pll_locked_i;
      lk_s_q    <= lk_meta_q;
    end
  end

  // State, shared cycle counter and status counters.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q <= StPllRst;
      cnt_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  // Next-state logic; every transition clears the counter so each state times from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    loss_d  = loss_q;

    if (reinit_i) begin
      // Software re-sequence beats any lock or timeout event, and is not a lock loss.
      state_d = StPllRst;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StPllRst: begin
          if (cnt_q == RstLast) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end
        end
        StWaitLock: begin
          if (lk_s_q) begin
            state_d = StStable;
            cnt_d   = '0;
          end else if (cnt_q == LockLast) begin
            cnt_d = '0;
            if (retry_q == MaxRetry) begin
              state_d = StFail;
            end else begin
              state_d = StPllRst;
              retry_d = retry_q + 3'd1;
            end
          end
        end
        StStable: begin
          if (!lk_s_q) begin
            // Glitch while qualifying: restart the lock wait without counting a retry.
            state_d = StWaitLock;
            cnt_d   = '0;
          end else if (cnt_q == StableLast) begin
            state_d = StRun;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        StRun: begin
          cnt_d = '0;
          if (!lk_s_q) begin
            state_d = StPllRst;
            if (loss_q != 8'hFF) begin
              loss_d = loss_q + 8'd1;
            end
          end
        end
        StFail: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = StPllRst;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode straight from registers so they cannot glitch on input changes.
  always_comb begin
    pll_rst_o       = (state_q == StPllRst) || (state_q == StFail);
    sys_rst_o       = (state_q != StRun);
    ready_o         = (state_q == StRun);
    fail_o          = (state_q == StFail);
    state_o         = state_q;
    retry_cnt_o     = retry_q;
    lock_loss_cnt_o = loss_q;
  end

endmodule
